hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 25 ++
 rtl/hazard_scoreboard_mdu_busy_ctr.sv | 25 ++
 rtl/hazard_scoreboard.sv | 142 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared hazard-resolution constants, also consumed by the instruction decoder.
package hazard_scoreboard_pkg;

  // D-relative use times; T_USE_NONE (all-ones) marks a source that is never read
  localparam int unsigned T_USE_D    = 0;
  localparam int unsigned T_USE_E    = 1;
  localparam int unsigned T_USE_M    = 2;
  localparam int unsigned T_USE_NONE = 15;

  // D-relative new times; T_NEW_NONE marks an instruction that writes no register
  localparam int unsigned T_NEW_NONE = 0;
  localparam int unsigned T_NEW_D    = 1;
  localparam int unsigned T_NEW_E    = 2;
  localparam int unsigned T_NEW_M    = 3;

  typedef enum logic [1:0] {
    SCU_MDU_USAGE_NOMDU   = 2'd0,
    SCU_MDU_USAGE_NOSTALL = 2'd1,
    SCU_MDU_USAGE_STALL   = 2'd2
  } scu_mdu_usage_e;

  // Forward select value meaning "take the operand from the register file"
  localparam int unsigned FWD_REGFILE = 0;

endpackage

// File: rtl/hazard_scoreboard_mdu_busy_ctr.sv
// Loadable down-counter that reports the multiply/divide unit as busy while nonzero.
module mdu_busy_ctr #(
  parameter int unsigned CW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_busy
);

  logic [CW-1:0] r_cnt;

  // Clear wins over load, load wins over the free-running decrement
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            r_cnt <= '0;
    else if (i_clr)          r_cnt <= '0;
    else if (i_load)         r_cnt <= i_load_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard: tracks in-flight writers after D, computes the
// D-stage stall and the forwarding source of each D-stage operand.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NSTG    = 3,
  parameter int unsigned TW      = 4,
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [4:0]                 d_rs,
  input  logic [4:0]                 d_rt,
  input  logic [TW-1:0]              d_tuse_rs,
  input  logic [TW-1:0]              d_tuse_rt,
  input  logic [TW-1:0]              d_tnew,
  input  logic [4:0]                 d_waddr,
  input  logic [1:0]                 d_mdu_usage,
  input  logic                       d_is_div,
  input  logic                       freeze,
  input  logic                       flush,
  output logic                       stall,
  output logic [$clog2(NSTG+1)-1:0]  fwd_rs,
  output logic [$clog2(NSTG+1)-1:0]  fwd_rt,
  output logic                       mdu_busy
);

  localparam int unsigned FW      = $clog2(NSTG + 1);
  localparam int unsigned MDU_MAX = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
  localparam int unsigned CW      = $clog2(MDU_MAX + 1);

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  logic          r_valid [NSTG];
  logic [4:0]    r_waddr [NSTG];
  logic [TW-1:0] r_tnew  [NSTG];
  logic          r_mdu_e;

  logic          w_nx_valid [NSTG];
  logic [4:0]    w_nx_waddr [NSTG];
  logic [TW-1:0] w_nx_tnew  [NSTG];

  logic [NSTG-1:0] w_match_rs, w_match_rt;
  logic            w_hit_rs, w_hit_rt;
  logic [TW-1:0]   w_rem_rs, w_rem_rt;
  logic [FW-1:0]   w_sel_rs, w_sel_rt;
  logic            w_adv, w_d_stall, w_mdu_stall, w_mdu_load;
  logic            w_d_is_mdu_stall;
  logic [CW-1:0]   w_mdu_val;

  assign w_adv            = ~freeze;
  assign w_d_is_mdu_stall = (d_mdu_usage == SCU_MDU_USAGE_STALL);

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_nx_valid[k] = ~stall & (d_tnew != '0) & (d_waddr != 5'd0);
      assign w_nx_waddr[k] = d_waddr;
      assign w_nx_tnew[k]  = sat_dec(d_tnew);
    end else begin : g_body
      assign w_nx_valid[k] = r_valid[k-1];
      assign w_nx_waddr[k] = r_waddr[k-1];
      assign w_nx_tnew[k]  = sat_dec(r_tnew[k-1]);
    end
    assign w_match_rs[k] = (d_rs != 5'd0) & r_valid[k] & (r_waddr[k] == d_rs);
    assign w_match_rt[k] = (d_rt != 5'd0) & r_valid[k] & (r_waddr[k] == d_rt);
  end

  // Stage entries: flush beats freeze, freeze holds everything, else shift in D
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NSTG; i++) begin
        r_valid[i] <= 1'b0;
        r_waddr[i] <= '0;
        r_tnew[i]  <= '0;
      end
      r_mdu_e <= 1'b0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NSTG; i++) begin
        r_valid[i] <= 1'b0;
        r_waddr[i] <= '0;
        r_tnew[i]  <= '0;
      end
      r_mdu_e <= 1'b0;
    end else if (w_adv) begin
      for (int unsigned i = 0; i < NSTG; i++) begin
        r_valid[i] <= w_nx_valid[i];
        r_waddr[i] <= w_nx_waddr[i];
        r_tnew[i]  <= w_nx_tnew[i];
      end
      r_mdu_e <= ~stall & w_d_is_mdu_stall;
    end
  end

  // Youngest (lowest index) matching entry is each source's producer
  always_comb begin
    w_hit_rs = 1'b0;
    w_rem_rs = '0;
    w_sel_rs = '0;
    w_hit_rt = 1'b0;
    w_rem_rt = '0;
    w_sel_rt = '0;
    for (int unsigned i = 0; i < NSTG; i++) begin
      if (w_match_rs[i] && !w_hit_rs) begin
        w_hit_rs = 1'b1;
        w_rem_rs = r_tnew[i];
        w_sel_rs = FW'(i + 1);
      end
      if (w_match_rt[i] && !w_hit_rt) begin
        w_hit_rt = 1'b1;
        w_rem_rt = r_tnew[i];
        w_sel_rt = FW'(i + 1);
      end
    end
  end

  assign w_d_stall = (w_hit_rs && (d_tuse_rs != '1) && (w_rem_rs > d_tuse_rs)) ||
                     (w_hit_rt && (d_tuse_rt != '1) && (w_rem_rt > d_tuse_rt));

  assign w_mdu_stall = (d_mdu_usage != SCU_MDU_USAGE_NOMDU) && (mdu_busy || r_mdu_e);

  assign stall  = w_d_stall | w_mdu_stall;
  assign fwd_rs = (w_hit_rs && (w_rem_rs == '0)) ? w_sel_rs : FW'(FWD_REGFILE);
  assign fwd_rt = (w_hit_rt && (w_rem_rt == '0)) ? w_sel_rt : FW'(FWD_REGFILE);

  assign w_mdu_load = w_adv & ~stall & w_d_is_mdu_stall;
  assign w_mdu_val  = d_is_div ? CW'(DIV_CYC) : CW'(MUL_CYC);

  mdu_busy_ctr #(
    .CW (CW)
  ) u_mdu_busy_ctr (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_clr      (flush),
    .i_load     (w_mdu_load),
    .i_load_val (w_mdu_val),
    .o_busy     (mdu_busy)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed instruction pairs push their
// expected {stall, fwd_rs, fwd_rt, mdu_busy}; a monitor compares mid-cycle.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int unsigned NSTG    = 3;
  localparam int unsigned TW      = 4;
  localparam int unsigned MUL_CYC = 5;
  localparam int unsigned DIV_CYC = 10;

  logic       clk, reset;
  logic [4:0] d_rs, d_rt, d_waddr;
  logic [3:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic [1:0] d_mdu_usage;
  logic       d_is_div, freeze, flush;
  logic       stall, mdu_busy;
  logic [1:0] fwd_rs, fwd_rt;

  hazard_scoreboard #(
    .NSTG    (NSTG),
    .TW      (TW),
    .MUL_CYC (MUL_CYC),
    .DIV_CYC (DIV_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_tuse_rs   (d_tuse_rs),
    .d_tuse_rt   (d_tuse_rt),
    .d_tnew      (d_tnew),
    .d_waddr     (d_waddr),
    .d_mdu_usage (d_mdu_usage),
    .d_is_div    (d_is_div),
    .freeze      (freeze),
    .flush       (flush),
    .stall       (stall),
    .fwd_rs      (fwd_rs),
    .fwd_rt      (fwd_rt),
    .mdu_busy    (mdu_busy)
  );

  typedef struct {
    string      nm;
    logic [5:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] NR = 4'hF;
  localparam logic [1:0] U_NO = SCU_MDU_USAGE_NOMDU;
  localparam logic [1:0] U_NS = SCU_MDU_USAGE_NOSTALL;
  localparam logic [1:0] U_ST = SCU_MDU_USAGE_STALL;

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [3:0] tu_rs, input logic [3:0] tu_rt,
                       input logic [3:0] tn, input logic [4:0] wa,
                       input logic [1:0] mu, input logic dv);
    d_rs = rs; d_rt = rt; d_tuse_rs = tu_rs; d_tuse_rt = tu_rt;
    d_tnew = tn; d_waddr = wa; d_mdu_usage = mu; d_is_div = dv;
  endtask

  task automatic nop();
    set_d(5'd0, 5'd0, NR, NR, 4'd0, 5'd0, U_NO, 1'b0);
  endtask

  // Queue the expectation for the current cycle, then move to the next one
  task automatic expect_cyc(input string nm, input logic s, input logic [1:0] fr,
                            input logic [1:0] frt, input logic b);
    exp_t e;
    e.nm = nm;
    e.v  = {s, fr, frt, b};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) expect_cyc("drain", 1'b0, 2'd0, 2'd0, 1'b0);
  endtask

  // Monitor: compare the DUT outputs against the oldest queued expectation
  exp_t       m_e;
  logic [5:0] m_got;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e   = q.pop_front();
      m_got = {stall, fwd_rs, fwd_rt, mdu_busy};
      n_checks++;
      if (m_got !== m_e.v) begin
        n_fail++;
        $display("FAIL %s: got stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b, expected stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b",
                 m_e.nm, m_got[5], m_got[4:3], m_got[2:1], m_got[0],
                 m_e.v[5], m_e.v[4:3], m_e.v[2:1], m_e.v[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset  = 1'b0;
    freeze = 1'b0;
    flush  = 1'b0;
    set_d(5'd1, 5'd0, 4'd0, NR, 4'd3, 5'd4, U_ST, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    expect_cyc("reset_outputs", 1'b0, 2'd0, 2'd0, 1'b0);
    reset = 1'b1;

    // jal then jr $31: result ready in E, forward from stage 1
    set_d(5'd0, 5'd0, NR, NR, 4'(T_NEW_D), 5'd31, U_NO, 1'b0);
    expect_cyc("jal_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    set_d(5'd31, 5'd0, 4'(T_USE_D), NR, 4'd0, 5'd0, U_NO, 1'b0);
    expect_cyc("jr_fwd_E", 1'b0, 2'd1, 2'd0, 1'b0);
    drain();

    // addu $1 then beq $1,$0: one stall, then forward from M
    set_d(5'd0, 5'd0, NR, NR, 4'(T_NEW_E), 5'd1, U_NO, 1'b0);
    expect_cyc("addu_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    set_d(5'd1, 5'd0, 4'(T_USE_D), 4'(T_USE_D), 4'd0, 5'd0, U_NO, 1'b0);
    expect_cyc("beq_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    expect_cyc("beq_fwd_M", 1'b0, 2'd2, 2'd0, 1'b0);
    drain();

    // lw $1 then add $3,$1,$2: one stall, then not-ready in M, ready in W
    set_d(5'd0, 5'd0, NR, NR, 4'(T_NEW_M), 5'd1, U_NO, 1'b0);
    expect_cyc("lw_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    set_d(5'd1, 5'd2, 4'(T_USE_E), 4'(T_USE_E), 4'(T_NEW_E), 5'd3, U_NO, 1'b0);
    expect_cyc("lw_use_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    expect_cyc("lw_use_M_nostall", 1'b0, 2'd0, 2'd0, 1'b0);
    expect_cyc("lw_fwd_W", 1'b0, 2'd3, 2'd0, 1'b0);
    drain();

    // write to $0 never registers a producer
    set_d(5'd0, 5'd0, NR, NR, 4'(T_NEW_M), 5'd0, U_NO, 1'b0);
    expect_cyc("w0_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    set_d(5'd0, 5'd0, 4'(T_USE_D), 4'(T_USE_D), 4'd0, 5'd0, U_NO, 1'b0);
    expect_cyc("w0_read", 1'b0, 2'd0, 2'd0, 1'b0);

    // two producers of $5: the younger one (in E) decides
    set_d(5'd0, 5'd0, NR, NR, 4'(T_NEW_D), 5'd5, U_NO, 1'b0);
    expect_cyc("r5_old", 1'b0, 2'd0, 2'd0, 1'b0);
    set_d(5'd0, 5'd0, NR, NR, 4'(T_NEW_M), 5'd5, U_NO, 1'b0);
    expect_cyc("r5_young", 1'b0, 2'd0, 2'd0, 1'b0);
    set_d(5'd5, 5'd5, 4'(T_USE_E), NR, 4'd0, 5'd0, U_NO, 1'b0);
    expect_cyc("r5_sel_E_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    expect_cyc("r5_sel_M_notready", 1'b0, 2'd0, 2'd0, 1'b0);
    expect_cyc("r5_fwd_W", 1'b0, 2'd3, 2'd3, 1'b0);
    drain();

    // freeze holds the entries, so the stall persists until release
    set_d(5'd0, 5'd0, NR, NR, 4'(T_NEW_E), 5'd2, U_NO, 1'b0);
    expect_cyc("frz_addu", 1'b0, 2'd0, 2'd0, 1'b0);
    set_d(5'd2, 5'd0, 4'(T_USE_D), NR, 4'd0, 5'd0, U_NO, 1'b0);
    freeze = 1'b1;
    expect_cyc("frz_stall1", 1'b1, 2'd0, 2'd0, 1'b0);
    expect_cyc("frz_stall2", 1'b1, 2'd0, 2'd0, 1'b0);
    freeze = 1'b0;
    expect_cyc("frz_release_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    expect_cyc("frz_fwd_M", 1'b0, 2'd2, 2'd0, 1'b0);
    drain();

    // flush (with freeze also high) during a lw stall clears the scoreboard
    set_d(5'd0, 5'd0, NR, NR, 4'(T_NEW_M), 5'd1, U_NO, 1'b0);
    expect_cyc("flush_lw", 1'b0, 2'd0, 2'd0, 1'b0);
    set_d(5'd1, 5'd2, 4'(T_USE_E), 4'(T_USE_E), 4'(T_NEW_E), 5'd3, U_NO, 1'b0);
    flush  = 1'b1;
    freeze = 1'b1;
    expect_cyc("flush_cycle_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    flush  = 1'b0;
    freeze = 1'b0;
    expect_cyc("after_flush", 1'b0, 2'd0, 2'd0, 1'b0);
    drain();

    // div then mflo: DIV_CYC stall cycles, busy falls with stall
    set_d(5'd0, 5'd0, NR, NR, 4'd0, 5'd0, U_ST, 1'b1);
    expect_cyc("div_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    set_d(5'd0, 5'd0, NR, NR, 4'(T_NEW_E), 5'd8, U_NS, 1'b0);
    for (int i = 0; i < 10; i++) expect_cyc("div_busy", 1'b1, 2'd0, 2'd0, 1'b1);
    expect_cyc("div_done", 1'b0, 2'd0, 2'd0, 1'b0);
    drain();

    // mult then mflo: MUL_CYC stall cycles; freeze does not hold the counter
    set_d(5'd0, 5'd0, NR, NR, 4'd0, 5'd0, U_ST, 1'b0);
    expect_cyc("mult_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    set_d(5'd0, 5'd0, NR, NR, 4'(T_NEW_E), 5'd8, U_NS, 1'b0);
    for (int i = 0; i < 5; i++) begin
      freeze = (i == 1 || i == 2);
      expect_cyc("mult_busy", 1'b1, 2'd0, 2'd0, 1'b1);
    end
    freeze = 1'b0;
    expect_cyc("mult_done", 1'b0, 2'd0, 2'd0, 1'b0);
    drain();

    // reset asserted mid-div drops busy without waiting for a clock edge
    set_d(5'd0, 5'd0, NR, NR, 4'd0, 5'd0, U_ST, 1'b1);
    expect_cyc("div2_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    set_d(5'd0, 5'd0, NR, NR, 4'(T_NEW_E), 5'd8, U_NS, 1'b0);
    expect_cyc("div2_busy", 1'b1, 2'd0, 2'd0, 1'b1);
    reset = 1'b0;
    expect_cyc("reset_mid_div", 1'b0, 2'd0, 2'd0, 1'b0);
    reset = 1'b1;
    expect_cyc("post_reset", 1'b0, 2'd0, 2'd0, 1'b0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
